// File: rtl/alu_seq_nbit_pkg.sv
// alu_pkg: shared definitions for the sequential N-bit ALU.
//   alu_op_e : 4-bit operation encodings (1010-1111 reserved)
//   state_e  : control FSM states
//   is_shift : true for the ops that run through the iterative shifter
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_SLT  = 4'b0010,
    OP_SLTU = 4'b0011,
    OP_AND  = 4'b0100,
    OP_OR   = 4'b0101,
    OP_XOR  = 4'b0110,
    OP_SLL  = 4'b0111,
    OP_SRL  = 4'b1000,
    OP_SRA  = 4'b1001
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_seq_nbit_if.sv
// alu_seq_nbit_if: operand/result handshake bundle for alu_seq_nbit.
//   IN_VALID/IN_READY   : op acceptance (IN_VALID && IN_READY)
//   ALU_OP, IN1, IN2    : op code and operands, sampled at acceptance
//   OUT_VALID/OUT_READY : result transfer (OUT_VALID && OUT_READY)
//   RESULT, ZERO, OVF   : registered result and flags
// slave is the ALU side, master the producer/consumer side.
interface alu_seq_nbit_if #(parameter int N = 32);
  logic         IN_VALID;
  logic         IN_READY;
  logic [3:0]   ALU_OP;
  logic [N-1:0] IN1;
  logic [N-1:0] IN2;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [N-1:0] RESULT;
  logic         ZERO;
  logic         OVF;

  modport slave (
    input  IN_VALID, ALU_OP, IN1, IN2, OUT_READY,
    output IN_READY, OUT_VALID, RESULT, ZERO, OVF
  );

  modport master (
    output IN_VALID, ALU_OP, IN1, IN2, OUT_READY,
    input  IN_READY, OUT_VALID, RESULT, ZERO, OVF
  );
endinterface

// File: rtl/alu_seq_nbit_core.sv
// alu_core_comb_nbit: purely combinational single-cycle ALU datapath.
//   op  : operation code
//   a,b : operands
//   res : result for ADD/SUB/SLT/SLTU/AND/OR/XOR, 0 for shifts and reserved
//   ovf : signed overflow for ADD/SUB, 0 otherwise
module alu_core_comb_nbit
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [3:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] res,
  output logic         ovf
);

  logic         sub;
  logic [N-1:0] b_eff;
  logic [N:0]   sum;
  logic         s_ovf;

  // One adder serves ADD, SUB and both compares; compares are subtractions.
  assign sub   = (op != OP_ADD);
  assign b_eff = sub ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, sub};
  // Overflow when both adder inputs agree in sign and the sum disagrees.
  assign s_ovf = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]);

  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        res = sum[N-1:0];
        ovf = s_ovf;
      end
      OP_SLT:  res[0] = sum[N-1] ^ s_ovf;  // true sign of A-B
      OP_SLTU: res[0] = ~sum[N];           // no carry out == borrow
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq_nbit.sv
// alu_seq_nbit: N-bit integer ALU with valid/ready on both sides.
//   CLK : clock, rising edge
//   RST : synchronous active-high reset (aborts any op in flight)
//   bus : alu_seq_nbit_if slave (handshakes, op, operands, result, flags)
// Non-shift ops finish in one cycle. Shifts move one bit per cycle; a shift
// by k yields OUT_VALID max(k,1) cycles after the accepting cycle, so the
// first bit is shifted on the accept edge and the last in the SHIFT state.
module alu_seq_nbit
  import alu_pkg::*;
#(
  parameter int N   = 32,
  parameter int SHW = $clog2(N)
) (
  input  logic        CLK,
  input  logic        RST,
  alu_seq_nbit_if.slave bus
);

  state_e         state;
  logic [N-1:0]   work;
  logic [SHW-1:0] cnt;
  logic [3:0]     sh_op;
  logic [N-1:0]   result;
  logic           zero;
  logic           ovf;
  logic           out_valid;

  logic           accept;
  logic [SHW-1:0] shamt;
  logic [N-1:0]   core_res;
  logic           core_ovf;
  logic           acc_shift;
  logic           acc_short;
  logic [N-1:0]   first_sh;
  logic [N-1:0]   next_sh;
  logic [N-1:0]   acc_res;

  function automatic logic [N-1:0] shift1(input logic [3:0] op, input logic [N-1:0] v);
    case (op)
      OP_SLL:  return {v[N-2:0], 1'b0};
      OP_SRA:  return {v[N-1], v[N-1:1]};
      default: return {1'b0, v[N-1:1]};
    endcase
  endfunction

  alu_core_comb_nbit #(.N(N)) u_core (
    .op  (bus.ALU_OP),
    .a   (bus.IN1),
    .b   (bus.IN2),
    .res (core_res),
    .ovf (core_ovf)
  );

  assign bus.IN_READY = !RST && ((state == S_IDLE) || ((state == S_DONE) && bus.OUT_READY));
  assign accept       = bus.IN_VALID && bus.IN_READY;
  assign shamt        = bus.IN2[SHW-1:0];

  assign acc_shift = is_shift(bus.ALU_OP);
  assign acc_short = (shamt <= SHW'(1));
  assign first_sh  = shift1(bus.ALU_OP, bus.IN1);
  assign next_sh   = shift1(sh_op, work);

  // Result of anything that completes straight from the accept edge.
  always_comb begin
    acc_res = core_res;
    if (acc_shift) acc_res = (shamt == '0) ? bus.IN1 : first_sh;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      work      <= '0;
      cnt       <= '0;
      sh_op     <= '0;
    end else if (accept) begin
      if (acc_shift && !acc_short) begin
        // cnt counts the shifts still owed after this edge.
        work      <= first_sh;
        cnt       <= shamt - SHW'(1);
        sh_op     <= bus.ALU_OP;
        out_valid <= 1'b0;
        state     <= S_SHIFT;
      end else begin
        result    <= acc_res;
        zero      <= (acc_res == '0);
        ovf       <= core_ovf;
        out_valid <= 1'b1;
        state     <= S_DONE;
      end
    end else begin
      case (state)
        S_SHIFT: begin
          if (cnt == SHW'(1)) begin
            result    <= next_sh;
            zero      <= (next_sh == '0);
            ovf       <= 1'b0;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            work <= next_sh;
            cnt  <= cnt - SHW'(1);
          end
        end
        S_DONE: begin
          if (bus.OUT_READY) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.OUT_VALID = out_valid;
  assign bus.RESULT    = result;
  assign bus.ZERO      = zero;
  assign bus.OVF       = ovf;

endmodule
